word_calculator: RTL and testbench

- Parametrised multi-cycle integer calculator; next generation of the board-level byte calculator.
- Performs ADD, SUB, MUL and DIV on WIDTH-bit unsigned operands with a start/busy/done handshake.
- MUL uses shift-add; DIV uses restoring division.
- Sits between switch/button input logic and the display driver; result is held stable for the display until the next operation completes.

---
 rtl/word_calculator.sv | 140 ++++++++++++++
 tb/tb_word_calculator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/word_calculator.sv
// word_calculator: multi-cycle unsigned ADD/SUB/MUL/DIV with a start/busy/done handshake.
// Optional feature: define REMAINDER_EN to add the DIV remainder output port.
module word_calculator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
`ifdef REMAINDER_EN
    output logic [WIDTH-1:0]   remainder,
`endif
    output logic               div_by_zero
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINISH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;

    // Shared accumulator: MUL keeps {partial_hi, multiplier_lo}, DIV keeps {remainder, quotient}.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc_in,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, mcand} : '0);
        return {sum, acc_in[WIDTH-1:1]};
    endfunction

    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc_in,
                                                    input logic [WIDTH-1:0]   divisor);
        logic [WIDTH:0]   shifted;
        logic [WIDTH-1:0] diff;
        shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - divisor;
        if (shifted >= {1'b0, divisor})
            return {diff, acc_in[WIDTH-2:0], 1'b1};
        else
            return {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    endfunction

    // The extra MSB of the difference is the borrow for unsigned a-b.
    assign add_full = {1'b0, opa} + {1'b0, opb};
    assign sub_full = {1'b0, opa} - {1'b0, opb};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            op_r        <= OP_ADD;
            opa         <= '0;
            opb         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
`ifdef REMAINDER_EN
            remainder   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        opa   <= a;
                        opb   <= b;
                        count <= '0;
                        busy  <= 1'b1;
                        if (op == OP_MUL) begin
                            acc   <= {{WIDTH{1'b0}}, b};
                            state <= ITER;
                        end else if (op == OP_DIV && b != '0) begin
                            acc   <= {{WIDTH{1'b0}}, a};
                            state <= ITER;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                ITER: begin
                    acc   <= (op_r == OP_MUL) ? mul_step(acc, opa) : div_step(acc, opb);
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                    div_by_zero <= 1'b0;
                    case (op_r)
                        OP_ADD: result <= {{(WIDTH-1){1'b0}}, add_full};
                        OP_SUB: result <= {{(WIDTH-1){1'b0}}, sub_full};
                        OP_MUL: result <= acc;
                        default: begin
                            if (opb == '0) begin
                                result      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                div_by_zero <= 1'b1;
                            end else begin
                                result <= {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
                            end
                        end
                    endcase
`ifdef REMAINDER_EN
                    if (op_r != OP_DIV)
                        remainder <= '0;
                    else if (opb == '0)
                        remainder <= opa;
                    else
                        remainder <= acc[2*WIDTH-1:WIDTH];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_calculator.sv
// Scoreboard bench for word_calculator (WIDTH=8): issue pushes expectations, monitor pops on done.
module tb_word_calculator;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           div_by_zero;
`ifdef REMAINDER_EN
    logic [W-1:0]   remainder;
`endif

    typedef struct {
        string        name;
        logic [15:0]  res;
        logic         dbz;
        logic [7:0]   rem;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   busy_cnt;

    word_calculator #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
`ifdef REMAINDER_EN
        .remainder   (remainder),
`endif
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] r, input logic z,
                         input logic [7:0] m, input int lat);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_accept: busy stuck at %b, expected 0", nm, busy);
            return;
        end
        e.name    = nm;
        e.res     = r;
        e.dbz     = z;
        e.rem     = m;
        e.lat     = lat;
        e.acc_cyc = cyc;
        sb.push_back(e);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({nm, "_pending"}, sb.size(), 0);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 result=0x%0h, expected no done", result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, result, e.res);
                    check({e.name, "_dbz"}, div_by_zero, e.dbz);
                    check({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
`ifdef REMAINDER_EN
                    check({e.name, "_rem"}, remainder, e.rem);
`endif
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_dbz", div_by_zero, 0);
`ifdef REMAINDER_EN
        check("reset_rem", remainder, 0);
`endif
        reset_n = 1'b1;

        issue("add_200_100", 2'b00, 8'd200, 8'd100, 16'h012C, 1'b0, 8'd0, 2);
        issue("sub_5_10",    2'b01, 8'd5,   8'd10,  16'h01FB, 1'b0, 8'd0, 2);
        issue("mul_max_max", 2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 8'd0, 10);

        // Count busy cycles and pulse a start mid-operation that must be dropped.
        busy_cnt = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            busy_cnt++;
            if (i == 3) begin
                op = 2'b00; a = 8'd1; b = 8'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("mul_busy_cycles", busy_cnt, 9);
        repeat (3) @(negedge clk);
        check("mul_result_held", result, 16'hFE01);

        issue("div_200_7",   2'b11, 8'd200, 8'd7,   16'h001C, 1'b0, 8'd4,   10);
        issue("mul_0_0",     2'b10, 8'd0,   8'd0,   16'h0000, 1'b0, 8'd0,   10);
        issue("add_0_0",     2'b00, 8'd0,   8'd0,   16'h0000, 1'b0, 8'd0,   2);
        issue("sub_0_0",     2'b01, 8'd0,   8'd0,   16'h0000, 1'b0, 8'd0,   2);
        issue("div_0_0",     2'b11, 8'd0,   8'd0,   16'h00FF, 1'b1, 8'd0,   2);
        issue("div_0_5",     2'b11, 8'd0,   8'd5,   16'h0000, 1'b0, 8'd0,   10);
        issue("div_13_1",    2'b11, 8'd13,  8'd1,   16'h000D, 1'b0, 8'd0,   10);
        issue("div_5_9",     2'b11, 8'd5,   8'd9,   16'h0000, 1'b0, 8'd5,   10);
        issue("add_255_255", 2'b00, 8'd255, 8'd255, 16'h01FE, 1'b0, 8'd0,   2);
        issue("sub_7_7",     2'b01, 8'd7,   8'd7,   16'h0000, 1'b0, 8'd0,   2);
        issue("sub_0_1",     2'b01, 8'd0,   8'd1,   16'h01FF, 1'b0, 8'd0,   2);
        issue("mul_15_17",   2'b10, 8'd15,  8'd17,  16'h00FF, 1'b0, 8'd0,   10);
        issue("mul_200_100", 2'b10, 8'd200, 8'd100, 16'h4E20, 1'b0, 8'd0,   10);
        issue("div_255_16",  2'b11, 8'd255, 8'd16,  16'h000F, 1'b0, 8'd15,  10);
        issue("div_255_255", 2'b11, 8'd255, 8'd255, 16'h0001, 1'b0, 8'd0,   10);
        issue("div_10_0",    2'b11, 8'd10,  8'd0,   16'h00FF, 1'b1, 8'd10,  2);
        issue("add_1_1",     2'b00, 8'd1,   8'd1,   16'h0002, 1'b0, 8'd0,   2);
        drain("main");

        // Abort a MUL with reset in its third ITER cycle.
        @(negedge clk);
        op = 2'b10; a = 8'd3; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("abort_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_dbz", div_by_zero, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (14) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        issue("add_1_2", 2'b00, 8'd1, 8'd2, 16'h0003, 1'b0, 8'd0, 2);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
